axi_inf_write_state_core: RTL and testbench

Write-side AXI4 master core: takes one burst request (length, address) from a write-FIFO status controller, issues the AW transaction, then streams W beats from a first-word-fall-through FIFO. It then collects the B response. It sits in the frame-write path (video in → packer → stream FIFO → this core → DDR). It is the write-direction counterpart of the AXI read state core used by the read path. Only one burst is outstanding at a time.

---
 rtl/axi_inf_write_state_core_if.sv | 53 +++++
 rtl/axi_inf_write_state_core.sv | 125 ++++++++++++
 tb/tb_axi_inf_write_state_core.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_inf_write_state_core_if.sv
// AXI4 write-channel bundle (AW, W, B) for axi_inf_write_state_core.
// Ports:
//   master modport : the core; drives AW/W and bready, observes the ready signals and the B response.
//   slave modport  : the memory side; the direction of every signal is the reverse of the master modport.
interface axi_inf_write_state_core_if #(
    parameter int IDSIZE = 3,
    parameter int LSIZE  = 9,
    parameter int ASIZE  = 29,
    parameter int DSIZE  = 256
);
    logic [IDSIZE-1:0]  axi_awid;
    logic [ASIZE-1:0]   axi_awaddr;
    logic [LSIZE-1:0]   axi_awlen;
    logic [2:0]         axi_awsize;
    logic [1:0]         axi_awburst;
    logic               axi_awlock;
    logic [3:0]         axi_awcache;
    logic [2:0]         axi_awprot;
    logic [3:0]         axi_awqos;
    logic               axi_awvalid;
    logic               axi_awready;

    logic [DSIZE-1:0]   axi_wdata;
    logic [DSIZE/8-1:0] axi_wstrb;
    logic               axi_wlast;
    logic               axi_wvalid;
    logic               axi_wready;

    logic [IDSIZE-1:0]  axi_bid;
    logic [1:0]         axi_bresp;
    logic               axi_bvalid;
    logic               axi_bready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
               axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
               axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready
    );
endinterface

// File: rtl/axi_inf_write_state_core.sv
// Write-side AXI4 master core. It accepts one burst request (length, address),
// issues the AW transaction, then streams W beats from a first-word-fall-through
// FIFO and finally collects the B response. Only one burst is outstanding at a time.
// Ports:
//   axi_aclk, axi_reset : clock; synchronous active-high reset
//   write_req, req_len, req_addr : burst request (sampled only when idle)
//   req_resp  : one-cycle pulse, the request has been accepted
//   req_done  : one-cycle pulse, the B response has been received
//   bresp_err : valid together with req_done; set when bresp[1] is 1
//   in_data, in_empty, rd_en : FWFT FIFO head word, empty flag and pop
//   axi : AW/W/B channels (master modport)
module axi_inf_write_state_core #(
    parameter int IDSIZE = 3,
    parameter int ID     = 0,
    parameter int LSIZE  = 9,
    parameter int ASIZE  = 29,
    parameter int DSIZE  = 256
) (
    input  logic             axi_aclk,
    input  logic             axi_reset,
    input  logic             write_req,
    input  logic [LSIZE-1:0] req_len,
    input  logic [ASIZE-1:0] req_addr,
    output logic             req_resp,
    output logic             req_done,
    output logic             bresp_err,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_empty,
    output logic             rd_en,
    axi_inf_write_state_core_if.master axi
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_BRESP
    } state_t;

    state_t           state;
    logic [LSIZE-1:0] len_r;
    logic [ASIZE-1:0] addr_r;
    logic [LSIZE-1:0] cnt;
    logic             awvalid_r;
    logic             bready_r;
    logic             in_w;
    logic             w_hs;

    // Fixed AW attributes: full-width INCR bursts, normal non-cacheable bufferable.
    assign axi.axi_awid    = IDSIZE'(ID);
    assign axi.axi_awsize  = 3'($clog2(DSIZE/8));
    assign axi.axi_awburst = 2'b01;
    assign axi.axi_awlock  = 1'b0;
    assign axi.axi_awcache = 4'b0011;
    assign axi.axi_awprot  = '0;
    assign axi.axi_awqos   = '0;
    assign axi.axi_awaddr  = addr_r;
    assign axi.axi_awlen   = len_r;
    assign axi.axi_awvalid = awvalid_r;
    assign axi.axi_bready  = bready_r;

    // W channel is a combinational window onto the FWFT FIFO head, so a beat
    // can be offered in the same cycle the FIFO becomes non-empty.
    assign in_w           = (state == S_W);
    assign axi.axi_wvalid = in_w && !in_empty;
    assign axi.axi_wdata  = in_data;
    assign axi.axi_wstrb  = '1;
    assign axi.axi_wlast  = in_w && (cnt == len_r);
    assign w_hs           = axi.axi_wvalid && axi.axi_wready;
    assign rd_en          = w_hs;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state     <= S_IDLE;
            len_r     <= '0;
            addr_r    <= '0;
            cnt       <= '0;
            awvalid_r <= 1'b0;
            bready_r  <= 1'b0;
            req_resp  <= 1'b0;
            req_done  <= 1'b0;
            bresp_err <= 1'b0;
        end else begin
            req_resp  <= 1'b0;
            req_done  <= 1'b0;
            bresp_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (write_req) begin
                        len_r     <= req_len;
                        addr_r    <= req_addr;
                        req_resp  <= 1'b1;
                        awvalid_r <= 1'b1;
                        state     <= S_AW;
                    end
                end
                S_AW: begin
                    if (axi.axi_awready) begin
                        awvalid_r <= 1'b0;
                        cnt       <= '0;
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        cnt <= cnt + 1'b1;
                        if (axi.axi_wlast) begin
                            bready_r <= 1'b1;
                            state    <= S_BRESP;
                        end
                    end
                end
                S_BRESP: begin
                    // bid is not compared: only one burst is ever outstanding.
                    if (axi.axi_bvalid) begin
                        bready_r  <= 1'b0;
                        req_done  <= 1'b1;
                        bresp_err <= axi.axi_bresp[1];
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_inf_write_state_core.sv
module tb_axi_inf_write_state_core;
    localparam int IDSIZE = 3;
    localparam int LSIZE  = 9;
    localparam int ASIZE  = 29;
    localparam int DSIZE  = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             write_req = 1'b0;
    logic [LSIZE-1:0] req_len = '0;
    logic [ASIZE-1:0] req_addr = '0;
    logic             req_resp, req_done, bresp_err, rd_en;
    logic [DSIZE-1:0] in_data = '0;
    logic             in_empty = 1'b1;

    always #5 clk = ~clk;

    axi_inf_write_state_core_if #(.IDSIZE(IDSIZE), .LSIZE(LSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE)) axi ();

    axi_inf_write_state_core #(
        .IDSIZE(IDSIZE), .ID(0), .LSIZE(LSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE)
    ) dut (
        .axi_aclk(clk), .axi_reset(rst), .write_req(write_req), .req_len(req_len),
        .req_addr(req_addr), .req_resp(req_resp), .req_done(req_done), .bresp_err(bresp_err),
        .in_data(in_data), .in_empty(in_empty), .rd_en(rd_en), .axi(axi)
    );

    typedef struct packed { logic [DSIZE-1:0] data; logic last; } wexp_t;
    typedef struct packed { logic [ASIZE-1:0] addr; logic [LSIZE-1:0] len; } awexp_t;
    typedef struct packed { logic err; int unsigned beats; } dexp_t;

    wexp_t            w_q[$];
    awexp_t           aw_q[$];
    dexp_t            d_q[$];
    bit               resp_q[$];
    logic [DSIZE-1:0] fifo_q[$];

    int checks = 0;
    int failures = 0;

    // slave configuration, written by the stimulus process only
    int unsigned cfg_aw_delay = 0;
    int unsigned cfg_b_delay = 1;
    int unsigned cfg_gap_at = 999;
    bit          cfg_wtoggle = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;

    // written by the monitor only
    bit          pop_req = 1'b0, wlast_hs = 1'b0, b_hs = 1'b0, aw_seen = 1'b0;
    int unsigned rd_cnt = 0, rd_total = 0, done_cnt = 0;

    task automatic check(input string name, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Slave / FIFO driver: updates inputs 1 time unit after the active edge.
    int unsigned aw_cnt = 0, pops = 0, gap_cnt = 0, b_wait = 0;
    bit          gap_done = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            axi.axi_awready = 1'b0;
            axi.axi_wready  = 1'b0;
            axi.axi_bvalid  = 1'b0;
            axi.axi_bresp   = 2'b00;
            axi.axi_bid     = '0;
            fifo_q.delete();
            aw_cnt = 0; pops = 0; gap_cnt = 0; b_wait = 0; gap_done = 1'b0;
        end else begin
            if (write_req) begin
                pops = 0;
                gap_done = 1'b0;
            end
            if (pop_req && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            if (gap_cnt > 0) gap_cnt--;
            else if (pops == cfg_gap_at && !gap_done) begin
                gap_cnt = 3;
                gap_done = 1'b1;
            end
            if (!axi.axi_awvalid) begin
                aw_cnt = 0;
                axi.axi_awready = 1'b0;
            end else begin
                aw_cnt++;
                axi.axi_awready = (aw_cnt > cfg_aw_delay);
            end
            axi.axi_wready = cfg_wtoggle ? ~axi.axi_wready : 1'b1;
            if (b_hs) axi.axi_bvalid = 1'b0;
            if (wlast_hs) begin
                if (cfg_b_delay <= 1) begin
                    axi.axi_bvalid = 1'b1;
                    axi.axi_bresp  = cfg_bresp;
                end else b_wait = cfg_b_delay - 1;
            end else if (b_wait > 0) begin
                b_wait--;
                if (b_wait == 0) begin
                    axi.axi_bvalid = 1'b1;
                    axi.axi_bresp  = cfg_bresp;
                end
            end
        end
        in_empty = (fifo_q.size() == 0) || (gap_cnt > 0);
        in_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        pop_req  = 1'b0;
        wlast_hs = 1'b0;
        b_hs     = 1'b0;
        if (rst) begin
            rd_cnt  = 0;
            aw_seen = 1'b0;
        end else begin
            if (req_resp) begin
                if (resp_q.size() == 0) fail_event("req_resp_unexpected");
                else begin
                    void'(resp_q.pop_front());
                    check("req_resp_with_awvalid", axi.axi_awvalid, 1);
                end
            end
            if (axi.axi_awvalid) begin
                if (aw_q.size() == 0) fail_event("awvalid_unexpected");
                else begin
                    check("awaddr", axi.axi_awaddr, aw_q[0].addr);
                    check("awlen", axi.axi_awlen, aw_q[0].len);
                    if (axi.axi_awready) begin
                        check("awsize", axi.axi_awsize, 5);
                        check("awburst", axi.axi_awburst, 1);
                        check("awcache", axi.axi_awcache, 3);
                        check("awid", axi.axi_awid, 0);
                        check("awlock_prot_qos", {axi.axi_awlock, axi.axi_awprot, axi.axi_awqos}, 0);
                        void'(aw_q.pop_front());
                        aw_seen = 1'b1;
                    end
                end
            end
            if (in_empty) begin
                check("wvalid_while_empty", axi.axi_wvalid, 0);
                check("rd_en_while_empty", rd_en, 0);
            end
            if (axi.axi_wvalid) begin
                check("w_after_aw", aw_seen, 1);
                if (w_q.size() == 0) fail_event("wvalid_unexpected");
                else begin
                    check("wdata", axi.axi_wdata, w_q[0].data);
                    check("wlast", axi.axi_wlast, w_q[0].last);
                    if (axi.axi_wready) begin
                        check("rd_en_on_beat", rd_en, 1);
                        check("wstrb", axi.axi_wstrb, {(DSIZE/8){1'b1}});
                        if (w_q[0].last) begin
                            wlast_hs = 1'b1;
                            aw_seen  = 1'b0;
                        end
                        void'(w_q.pop_front());
                        rd_cnt++;
                        rd_total++;
                    end else check("rd_en_stalled", rd_en, 0);
                end
            end else if (rd_en) fail_event("rd_en_without_wvalid");
            b_hs    = axi.axi_bvalid && axi.axi_bready;
            pop_req = rd_en;
            if (req_done) begin
                if (d_q.size() == 0) fail_event("req_done_unexpected");
                else begin
                    check("bresp_err", bresp_err, d_q[0].err);
                    check("rd_en_count", rd_cnt, d_q[0].beats);
                    void'(d_q.pop_front());
                end
                rd_cnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic prepare(input int unsigned len, input logic [ASIZE-1:0] addr,
                           input int unsigned aw_d, input bit tog, input int unsigned gap,
                           input int unsigned b_d, input logic [1:0] br, input logic [DSIZE-1:0] base);
        cfg_aw_delay = aw_d;
        cfg_wtoggle  = tog;
        cfg_gap_at   = gap;
        cfg_b_delay  = b_d;
        cfg_bresp    = br;
        for (int unsigned i = 0; i <= len; i++) begin
            fifo_q.push_back(base + DSIZE'(i));
            w_q.push_back('{data: base + DSIZE'(i), last: (i == len)});
        end
        aw_q.push_back('{addr: addr, len: LSIZE'(len)});
        resp_q.push_back(1'b1);
        d_q.push_back('{err: br[1], beats: len + 1});
    endtask

    task automatic issue_req(input int unsigned len, input logic [ASIZE-1:0] addr);
        @(posedge clk); #2;
        write_req = 1'b1;
        req_len   = LSIZE'(len);
        req_addr  = addr;
        @(posedge clk); #2;
        write_req = 1'b0;
    endtask

    task automatic wait_done(input int unsigned start);
        for (int i = 0; i < 500 && done_cnt == start; i++) @(posedge clk);
        if (done_cnt == start) fail_event("req_done_timeout");
        repeat (2) @(posedge clk);
    endtask

    task automatic run_burst(input int unsigned len, input logic [ASIZE-1:0] addr,
                             input int unsigned aw_d, input bit tog, input int unsigned gap,
                             input int unsigned b_d, input logic [1:0] br, input logic [DSIZE-1:0] base);
        int unsigned s;
        s = done_cnt;
        prepare(len, addr, aw_d, tog, gap, b_d, br, base);
        issue_req(len, addr);
        wait_done(s);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_resp"}, req_resp, 0);
        check({tag, "_req_done"}, req_done, 0);
        check({tag, "_bresp_err"}, bresp_err, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_awvalid"}, axi.axi_awvalid, 0);
        check({tag, "_wvalid"}, axi.axi_wvalid, 0);
        check({tag, "_wlast"}, axi.axi_wlast, 0);
        check({tag, "_bready"}, axi.axi_bready, 0);
        check({tag, "_awaddr"}, axi.axi_awaddr, 0);
        check({tag, "_awlen"}, axi.axi_awlen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // single beat, bvalid two cycles after the wlast beat
        run_burst(0, 29'h100, 0, 1'b0, 999, 2, 2'b00, 256'h1000);
        // awready held off for 3 cycles, 16 beats
        run_burst(15, 29'h0400, 3, 1'b0, 999, 1, 2'b00, 256'h2000);
        // wready toggling plus a 3-cycle empty gap after 3 beats
        run_burst(7, 29'h2000, 0, 1'b1, 3, 1, 2'b00, 256'h3000);
        // error response then a clean one
        run_burst(2, 29'h300, 0, 1'b0, 999, 1, 2'b10, 256'h4000);
        run_burst(1, 29'h340, 0, 1'b0, 999, 3, 2'b00, 256'h5000);

        // request while busy in W is ignored
        s = done_cnt;
        prepare(15, 29'h4000, 0, 1'b0, 999, 1, 2'b00, 256'h6000);
        issue_req(15, 29'h4000);
        for (int i = 0; i < 50 && rd_total == 0; i++) @(posedge clk);
        begin
            int unsigned r;
            r = rd_total;
            for (int i = 0; i < 50 && rd_total == r; i++) @(posedge clk);
        end
        issue_req(3, 29'h999);
        @(negedge clk);
        check("busy_awaddr_latched", axi.axi_awaddr, 29'h4000);
        check("busy_awlen_latched", axi.axi_awlen, 15);
        wait_done(s);
        run_burst(1, 29'h500, 0, 1'b0, 999, 1, 2'b00, 256'h7000);

        // reset after 5 of 16 beats
        s = rd_total;
        prepare(15, 29'h8000, 0, 1'b0, 999, 1, 2'b00, 256'h8000);
        issue_req(15, 29'h8000);
        for (int i = 0; i < 100 && rd_total < s + 5; i++) @(posedge clk);
        if (rd_total < s + 5) fail_event("reset_wait_timeout");
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        w_q.delete();
        aw_q.delete();
        d_q.delete();
        resp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run_burst(3, 29'h200, 0, 1'b0, 999, 1, 2'b00, 256'h9000);

        check("w_q_drained", w_q.size(), 0);
        check("aw_q_drained", aw_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
